rx_ber_checker: RTL

Receive-side checker downstream of the polyphase TX FIR. Consumes the FIR's 4-samples-per-symbol S(8,6) output and decimates it at a selectable phase. It slices each kept sample to a bit, self-synchronises a local PRBS9 to the bit stream, then counts received bits and bit errors for BER measurement.

---
 rtl/rx_ber_checker.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/rx_ber_checker.sv
// rx_ber_checker: decimates the polyphase FIR output, slices to bits and
// self-synchronises a PRBS9 reference to count received bits and errors.
module rx_ber_checker #(
  parameter int NB_INPUT   = 8,
  parameter int NB_COUNT   = 32,
  parameter int VERIFY_LEN = 64,
  parameter int ERR_THRESH = 0
) (
  input  logic                clock,
  input  logic                i_reset,
  input  logic                i_enable,
  input  logic [NB_INPUT-1:0] i_sample,
  input  logic [1:0]          i_counterMux,
  input  logic [1:0]          i_phase,
  input  logic                i_resync,
  output logic                o_sym_valid,
  output logic                o_sym_bit,
  output logic                o_lock,
  output logic [NB_COUNT-1:0] o_bit_count,
  output logic [NB_COUNT-1:0] o_err_count
);

  localparam int NB_VER = $clog2(VERIFY_LEN + 1);
  localparam int THR_CLAMP =
    (ERR_THRESH > VERIFY_LEN) ? VERIFY_LEN : ERR_THRESH;
  localparam logic [NB_VER-1:0] VER_LEN = NB_VER'(VERIFY_LEN);
  localparam logic [NB_VER-1:0] VER_THR = NB_VER'(THR_CLAMP);
  localparam logic [3:0] LOAD_LAST = 4'd8;

  typedef enum logic [1:0] {
    ST_LOAD,
    ST_VERIFY,
    ST_LOCKED
  } state_t;

  state_t              state_q;
  logic                valid_q;
  logic                bit_q;
  logic                lock_q;
  logic [8:0]          lfsr_q;
  logic [3:0]          load_cnt_q;
  logic [NB_VER-1:0]   ver_cnt_q;
  logic [NB_VER-1:0]   ver_err_q;
  logic [NB_COUNT-1:0] bit_cnt_q;
  logic [NB_COUNT-1:0] err_cnt_q;

  logic                dec;
  logic                exp_bit;
  logic                mis;
  logic [NB_VER-1:0]   ver_cnt_d;
  logic [NB_VER-1:0]   ver_err_d;
  logic [NB_COUNT-1:0] bit_cnt_d;
  logic [NB_COUNT-1:0] err_cnt_d;
  logic                unused_sample;

  // Only the sign bit matters to the slicer.
  assign unused_sample = &{1'b0, i_sample[NB_INPUT-2:0]};

  assign dec = i_enable & (i_counterMux == i_phase);

  always_ff @(posedge clock) begin
    if (i_reset) begin
      valid_q <= 1'b0;
      bit_q   <= 1'b0;
    end else begin
      valid_q <= dec;
      if (dec) begin
        bit_q <= i_sample[NB_INPUT-1];
      end
    end
  end

  assign exp_bit = lfsr_q[8] ^ lfsr_q[4];
  assign mis     = bit_q ^ exp_bit;

  always_comb begin
    ver_cnt_d = ver_cnt_q + NB_VER'(1);
    ver_err_d = ver_err_q + NB_VER'(mis);
    bit_cnt_d = bit_cnt_q;
    err_cnt_d = err_cnt_q;
    if (!(&bit_cnt_q)) begin
      bit_cnt_d = bit_cnt_q + NB_COUNT'(1);
    end
    if (mis && !(&err_cnt_q)) begin
      err_cnt_d = err_cnt_q + NB_COUNT'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (i_reset) begin
      state_q    <= ST_LOAD;
      lfsr_q     <= '0;
      load_cnt_q <= '0;
      ver_cnt_q  <= '0;
      ver_err_q  <= '0;
      lock_q     <= 1'b0;
      bit_cnt_q  <= '0;
      err_cnt_q  <= '0;
    end else if (i_resync) begin
      state_q    <= ST_LOAD;
      load_cnt_q <= '0;
      lock_q     <= 1'b0;
      bit_cnt_q  <= '0;
      err_cnt_q  <= '0;
    end else if (valid_q) begin
      unique case (state_q)
        ST_LOAD: begin
          lfsr_q <= {lfsr_q[7:0], bit_q};
          if (load_cnt_q == LOAD_LAST) begin
            load_cnt_q <= '0;
            ver_cnt_q  <= '0;
            ver_err_q  <= '0;
            state_q    <= ST_VERIFY;
          end else begin
            load_cnt_q <= load_cnt_q + 4'd1;
          end
        end
        ST_VERIFY: begin
          lfsr_q    <= {lfsr_q[7:0], exp_bit};
          ver_cnt_q <= ver_cnt_d;
          ver_err_q <= ver_err_d;
          if (ver_cnt_d == VER_LEN) begin
            if (ver_err_d <= VER_THR) begin
              state_q <= ST_LOCKED;
              lock_q  <= 1'b1;
            end else begin
              state_q    <= ST_LOAD;
              load_cnt_q <= '0;
            end
          end
        end
        ST_LOCKED: begin
          lfsr_q    <= {lfsr_q[7:0], exp_bit};
          bit_cnt_q <= bit_cnt_d;
          err_cnt_q <= err_cnt_d;
        end
        default: begin
          state_q    <= ST_LOAD;
          load_cnt_q <= '0;
          lock_q     <= 1'b0;
        end
      endcase
    end
  end

  assign o_sym_valid = valid_q;
  assign o_sym_bit   = bit_q;
  assign o_lock      = lock_q;
  assign o_bit_count = bit_cnt_q;
  assign o_err_count = err_cnt_q;

endmodule
